midi_writer: RTL

- UART MIDI transmitter; the output-side counterpart to the MIDI receive path (midi_reader).
- Accepts one channel-voice message per handshake (status nibble, channel, up to two data bytes).
- Frames the message into MIDI bytes and serialises them 8N1 at 31250 baud on a single wire.
- Intended uses: a MIDI-thru or MIDI-out jack, and loopback verification of the receive path.

---
 rtl/midi_writer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/midi_writer.sv
// midi_writer: channel-voice MIDI transmitter. Accepts one message per
// handshake, frames it into status/data bytes and serialises each byte 8N1.
//
// Handshake: a message is taken on any cycle where valid_in && ready_out.
// ready_out is high only while idle. valid_in while ready_out is low is
// ignored, and nothing is queued. Messages with a system or undefined status
// nibble complete the handshake but are dropped without transmitting.
module midi_writer #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status,
  input  logic [3:0] channel,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  n_bytes_q, n_bytes_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [7:0]  last_status_q, last_status_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic [1:0]  msg_len;
  logic [7:0]  status_byte;
  logic        skip_status;
  logic        bit_done;
  logic [7:0]  cur_byte_d;
  logic        unused_bits;

  // Data byte MSBs are forced to zero on the wire, so bit 7 is never used.
  assign unused_bits = data_byte1[7] ^ data_byte2[7];

  assign status_byte = {status, channel};
  assign skip_status = (RUNNING_STATUS != 0) && (status_byte == last_status_q);
  assign bit_done    = (cnt_q == CNT_MAX);
  assign ready_out   = (state_q == S_IDLE);
  assign tx_wire_out = tx_q;
  assign busy_out    = busy_q;

  // Message length from the status nibble; 0 means drop the message.
  always_comb begin
    msg_len = 2'd0;
    case (status)
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
      4'hC, 4'hD:                   msg_len = 2'd2;
      default:                      msg_len = 2'd0;
    endcase
  end

  // State register: all flops, synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      byte_idx_q    <= '0;
      n_bytes_q     <= '0;
      byte0_q       <= '0;
      byte1_q       <= '0;
      byte2_q       <= '0;
      last_status_q <= 8'h00;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      n_bytes_q     <= n_bytes_d;
      byte0_q       <= byte0_d;
      byte1_q       <= byte1_d;
      byte2_q       <= byte2_d;
      last_status_q <= last_status_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic: accept/frame a message and step through the bit cells.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    n_bytes_d     = n_bytes_q;
    byte0_d       = byte0_q;
    byte1_d       = byte1_q;
    byte2_d       = byte2_q;
    last_status_d = last_status_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in && (msg_len != 2'd0)) begin
          state_d       = S_START;
          cnt_d         = '0;
          bit_idx_d     = '0;
          byte_idx_d    = '0;
          last_status_d = status_byte;
          if (skip_status) begin
            // Running status: the list starts at data byte 1.
            byte0_d   = {1'b0, data_byte1[6:0]};
            byte1_d   = {1'b0, data_byte2[6:0]};
            byte2_d   = 8'h00;
            n_bytes_d = msg_len - 2'd1;
          end else begin
            byte0_d   = status_byte;
            byte1_d   = {1'b0, data_byte1[6:0]};
            byte2_d   = {1'b0, data_byte2[6:0]};
            n_bytes_d = msg_len;
          end
        end
      end
      S_START: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) begin
          if ((byte_idx_q + 2'd1) < n_bytes_q) begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the line level for the next cycle, registered so it is glitch-free.
  always_comb begin
    cur_byte_d = byte2_d;
    case (byte_idx_d)
      2'd0:    cur_byte_d = byte0_d;
      2'd1:    cur_byte_d = byte1_d;
      default: cur_byte_d = byte2_d;
    endcase
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule
